// File: rtl/jesd_tx_octet_mux.sv
// Lane TX octet generator: CGS commas, ILA with config/FCHK, or user data with /A/ /F/ substitution.
// One-cycle registered latency; no backpressure, user data is consumed every DATA cycle (user_rdy).
module jesd_tx_octet_mux #(
  parameter int K = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [2:0]   data_ctrl,
  input  logic [3:0]   ila_mf,
  input  logic [103:0] cfg_octets,
  input  logic [31:0]  tx_user_data,
  output logic         user_rdy,
  output logic [31:0]  tx_data,
  output logic [3:0]   tx_k,
  output logic         lmfc_end
);

  localparam int            FW   = $clog2(K);
  localparam logic [FW-1:0] LAST = FW'(K - 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [31:0]   tx_data_q, tx_data_d;
  logic [3:0]    tx_k_q, tx_k_d;
  logic          lmfc_end_q, lmfc_end_d;
  logic          user_rdy_q, user_rdy_d;
  logic [7:0]    prev_last_q, prev_last_d;
  logic          prev_vld_q, prev_vld_d;
  logic          prev_rep_q, prev_rep_d;

  logic [7:0]    fchk;
  logic [7:0]    cfg_arr [16];
  logic [31:0]   ila_dat;
  logic [3:0]    ila_k;
  logic [7:0]    fcnt_x4;
  logic [3:0]    pos;
  logic          mf2;
  logic [7:0]    oct3;
  logic          match, rep_a, rep_f;

  // Config stream as seen on the wire: octets 0..12 then FCHK as octet 13.
  always_comb begin
    fchk = '0;
    for (int n = 0; n < 13; n++) begin
      cfg_arr[n] = cfg_octets[8*n +: 8];
      fchk       = fchk + cfg_octets[8*n +: 8];
    end
    cfg_arr[13] = fchk;
    cfg_arr[14] = '0;
    cfg_arr[15] = '0;
  end

  always_comb begin
    ila_dat = '0;
    ila_k   = '0;
    pos     = '0;
    fcnt_x4 = 8'({fcnt_q, 2'b00});
    mf2     = (ila_mf == 4'b0010);
    for (int i = 0; i < 4; i++) begin
      pos                = {fcnt_q[1:0], 2'(i)};
      ila_dat[8*i +: 8]  = fcnt_x4 + 8'(i);
      if (mf2 && (fcnt_q < FW'(4)) && (pos >= 4'd2))
        ila_dat[8*i +: 8] = cfg_arr[pos - 4'd2];
    end
    if (fcnt_q == '0) begin
      ila_dat[7:0] = 8'h1C;
      ila_k[0]     = 1'b1;
      if (mf2) begin
        ila_dat[15:8] = 8'h9C;
        ila_k[1]      = 1'b1;
      end
    end
    if (fcnt_q == LAST) begin
      ila_dat[31:24] = 8'h7C;
      ila_k[3]       = 1'b1;
    end
  end

  // /F/ is suppressed right after a replaced frame; /A/ at the multiframe end is not.
  always_comb begin
    oct3  = tx_user_data[31:24];
    match = prev_vld_q && (oct3 == prev_last_q);
    rep_a = match && (fcnt_q == LAST);
    rep_f = match && (fcnt_q != LAST) && !prev_rep_q;
  end

  always_comb begin
    fcnt_d      = (fcnt_q == LAST) ? '0 : fcnt_q + 1'b1;
    lmfc_end_d  = (fcnt_q == LAST);
    tx_data_d   = 32'hBCBCBCBC;
    tx_k_d      = 4'hF;
    user_rdy_d  = 1'b0;
    prev_last_d = prev_last_q;
    prev_vld_d  = 1'b0;
    prev_rep_d  = 1'b0;
    case (data_ctrl)
      3'b010: begin
        tx_data_d = ila_dat;
        tx_k_d    = ila_k;
      end
      3'b100: begin
        tx_data_d   = tx_user_data;
        tx_k_d      = 4'h0;
        user_rdy_d  = 1'b1;
        prev_last_d = oct3;
        prev_vld_d  = 1'b1;
        prev_rep_d  = rep_a || rep_f;
        if (rep_a) begin
          tx_data_d[31:24] = 8'h7C;
          tx_k_d[3]        = 1'b1;
        end else if (rep_f) begin
          tx_data_d[31:24] = 8'hFC;
          tx_k_d[3]        = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q      <= '0;
      tx_data_q   <= 32'hBCBCBCBC;
      tx_k_q      <= 4'hF;
      lmfc_end_q  <= 1'b0;
      user_rdy_q  <= 1'b0;
      prev_last_q <= '0;
      prev_vld_q  <= 1'b0;
      prev_rep_q  <= 1'b0;
    end else begin
      fcnt_q      <= fcnt_d;
      tx_data_q   <= tx_data_d;
      tx_k_q      <= tx_k_d;
      lmfc_end_q  <= lmfc_end_d;
      user_rdy_q  <= user_rdy_d;
      prev_last_q <= prev_last_d;
      prev_vld_q  <= prev_vld_d;
      prev_rep_q  <= prev_rep_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_k     = tx_k_q;
  assign lmfc_end = lmfc_end_q;
  assign user_rdy = user_rdy_q;

endmodule

// File: doc/jesd_tx_octet_mux.md
# jesd_tx_octet_mux

Lane transmit-path octet generator sitting directly downstream of the link state machine. It consumes the one-hot link phase (`data_ctrl`) and the one-hot ILA multiframe index (`ila_mf`). Each clock it produces a 4-octet word plus K-flags for the 8b/10b encoder: CGS comma stream, ILA sequence with configuration and FCHK, or user data with alignment-character replacement. It also owns the local frame/multiframe counter and emits the LMFC pulse used upstream.

## Interface
- `K`, 32: frames per multiframe; legal 17..32. F is fixed at 4, so one frame equals one clock word.
- `clk`  in  1  link clock, one frame per cycle.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_ctrl`  in  3  link phase, one-hot: 001 = CGS, 010 = ILA, 100 = DATA.
- `ila_mf`  in  4  one-hot ILA multiframe index; 0001 = first multiframe.
- `cfg_octets`  in  104  link config octets 0..12; octet n at `[8n+7:8n]`.
- `tx_user_data`  in  32  user frame; octet i at `[8i+7:8i]`; octet 0 is transmitted first.
- `user_rdy`  out  1  registered; 1 in the cycle where `tx_user_data` is consumed.
- `tx_data`  out  32  output word; same octet ordering as `tx_user_data`.
- `tx_k`  out  4  bit i = 1 marks octet i as a K character.
- `lmfc_end`  out  1  1 on the output word that is the last frame of a multiframe.

## Operation
- `fcnt`: free-running 0..K-1 frame counter, +1 every cycle, wraps K-1 → 0. Unaffected by `data_ctrl`.
- CGS (001), and any non-one-hot `data_ctrl` including 000: every octet is K28.5 (0xBC), `tx_k` = 4'hF.
- ILA (010), position given by `fcnt` and octet index i:
  - Default octet value is the ramp `(4*fcnt + i) mod 256`, with k = 0.
  - `fcnt` = 0, i = 0: /R/ K28.0 (0x1C), k = 1.
  - `fcnt` = K-1, i = 3: /A/ K28.3 (0x7C), k = 1.
  - When `ila_mf` = 0010 only:
    - `fcnt` = 0, i = 1: /Q/ K28.4 (0x9C), k = 1.
    - Config octets 0..13 fill, in order, `fcnt` 0 octets 2..3, then `fcnt` 1..3 octets 0..3. All have k = 0.
  - Config octet 13 is FCHK = sum of config octets 0..12, mod 256, computed internally.
  - ILA entered mid-multiframe: content follows the current `fcnt` position; no realignment.
  - Non-one-hot `ila_mf`: treated as a non-second multiframe, i.e. no /Q/ and no config.
- DATA (100): octets 0..2 pass through with k = 0. Octet 3 (last octet of the frame) is subject to replacement:
  - `prev_last` holds the unreplaced octet 3 of the previous DATA frame; `prev_vld` marks it valid; `prev_rep` records whether the previous output frame was replaced.
  - `fcnt` = K-1, `prev_vld`, and octet 3 == `prev_last`: output 0x7C with k = 1 (/A/).
  - Otherwise, `fcnt` ≠ K-1, `prev_vld`, octet 3 == `prev_last`, and `!prev_rep`: output 0xFC with k = 1 (/F/).
  - `prev_last` is always updated with the original, unreplaced octet.
  - `prev_vld` and `prev_rep` clear in any cycle where `data_ctrl` ≠ 100. The first DATA frame is never replaced.
- `user_rdy` is asserted with the output word built from `tx_user_data`.

## Timing
- All outputs are registered. Latency is 1 cycle: inputs and `fcnt` sampled at edge n appear on `tx_data`/`tx_k`/`lmfc_end`/`user_rdy` after edge n+1.
- A phase change on `data_ctrl` takes effect on the very next output word; there is no draining.
- `lmfc_end` = 1 exactly once every K cycles, in all phases.
- Reset values: `tx_data` = 32'hBCBCBCBC, `tx_k` = 4'hF, `lmfc_end` = 0, `user_rdy` = 0, `fcnt` = 0, `prev_vld`/`prev_rep`/`prev_last` = 0.
- Reset asserted mid-ILA or mid-DATA: outputs return to reset values immediately (asynchronously). After release, `fcnt` restarts at 0 and the first `lmfc_end` occurs on the K-th output word.

## Test plan
- Reset, then hold `data_ctrl` = 001 → `tx_data` = BCBCBCBC, `tx_k` = F every cycle; `lmfc_end` every 32 cycles, first on the 32nd word.
- ILA from `fcnt` = 0, `ila_mf` = 0010, `cfg_octets` all 0x01 → word 0 octets 1C,9C,01,01 with k = 0011; FCHK octet = 0x0D at `fcnt` 3 octet 3; word 31 octet 3 = 7C with k = 1000.
- ILA with `ila_mf` = 0100 → word 0 octet 0 = 1C (k), octet 1 = ramp 0x01; word 5 = 0x17161514, `tx_k` = 0.
- DATA with octet 3 = 0x55 for 3 consecutive frames at `fcnt` 5,6,7 → outputs 0x55, FC(k), 0x55 (/F/ suppressed after a replaced frame). Same octet value at `fcnt` 31 → 7C(k).
- `data_ctrl` = 011 → CGS output. DATA → CGS → DATA → first DATA frame is never replaced.
- Reset pulse mid-ILA → next cycle `tx_data` = BCBCBCBC, `tx_k` = F, `fcnt` restarts at 0.
